// File: rtl/instr_decoder.sv
// instr_decoder: byte-level SPI transaction decoder driving register file read/write strobes
//   clk         in   main clock, posedge
//   rst_n       in   asynchronous reset, active low
//   byte_sync   in   one-cycle pulse, data_in holds a complete received byte
//   data_in     in   [7:0] received MOSI byte
//   data_out    out  [7:0] byte for the next MISO shift, held until overwritten
//   read        out  one-cycle read strobe
//   write       out  one-cycle write strobe
//   addr        out  [5:0] register address, held until next instruction byte
//   data_read   in   [7:0] register file read data, valid while read=1
//   data_write  out  [7:0] write data, held until next write
//   timeout     out  one-cycle abort pulse
//   Optional inter-byte timeout enabled by defining DECODER_TIMEOUT_EN (TIMEOUT_CYCLES clocks).
module instr_decoder #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_sync,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       read,
    output logic       write,
    output logic [5:0] addr,
    input  logic [7:0] data_read,
    output logic [7:0] data_write,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, WR_DATA, RD_CAP, RD_RESP} state_t;
    state_t     state, state_nxt;
    logic [5:0] addr_nxt;
    logic [7:0] data_out_nxt, data_write_nxt;
    logic       read_nxt, write_nxt, expire;
`ifdef DECODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          waiting;
    assign waiting = (state == WR_DATA) || (state == RD_RESP);
    // expiry fires on the cycle the count would reach TIMEOUT_CYCLES; a byte on that cycle wins
    assign expire = waiting && !byte_sync && (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= (byte_sync || !waiting || state_nxt != state) ? '0 : cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign expire = 1'b0;
`endif
    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        data_out_nxt   = data_out;
        data_write_nxt = data_write;
        read_nxt       = 1'b0;
        write_nxt      = 1'b0;
        case (state)
            IDLE: if (byte_sync) begin
                addr_nxt  = data_in[5:0];
                read_nxt  = !data_in[7];
                state_nxt = data_in[7] ? WR_DATA : RD_CAP;
            end
            WR_DATA: if (byte_sync) begin
                data_write_nxt = data_in;
                write_nxt      = 1'b1;
                state_nxt      = IDLE;
            end else if (expire) state_nxt = IDLE;
            // a byte landing during capture is the response slot itself
            RD_CAP: begin
                data_out_nxt = data_read;
                state_nxt    = byte_sync ? IDLE : RD_RESP;
            end
            RD_RESP: state_nxt = (byte_sync || expire) ? IDLE : RD_RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            data_out   <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            addr       <= addr_nxt;
            data_write <= data_write_nxt;
            data_out   <= data_out_nxt;
            timeout    <= expire;
        end
    end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed-vector bench for instr_decoder with a transaction-level reference model
module tb_instr_decoder;
    localparam int TO = 16;
    localparam int R_INSTR = 0, R_DATA = 1, R_RESP = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       byte_sync = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out, data_read, data_write;
    logic       read, write, timeout;
    logic [5:0] addr;
    logic [7:0] regs [64];
    int vectors = 0, miscompares = 0;
    int rc = 0, wc = 0, tc = 0;
    bit en = 1'b0;
    logic       m_read = 0, m_write = 0, m_to = 0, cap;
    logic [5:0] m_addr = 0;
    logic [7:0] m_dw = 0, m_do = 0;
    int role = R_INSTR, idle = 0;

    instr_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .data_in(data_in),
        .data_out(data_out), .read(read), .write(write), .addr(addr),
        .data_read(data_read), .data_write(data_write), .timeout(timeout)
    );

    always #5 clk = ~clk;
    // register file: data only meaningful while read is high
    assign data_read = read ? regs[addr] : 8'hEE;

    // model: each byte plays a role (instruction, write data, read response) in the transaction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_read = 0; m_write = 0; m_to = 0; m_addr = 0; m_dw = 0; m_do = 0;
            role = R_INSTR; idle = 0;
        end else begin
            cap = m_read;
            m_read = 0; m_write = 0; m_to = 0;
            if (cap) begin
                m_do = regs[m_addr];
                role = byte_sync ? R_INSTR : R_RESP;
                idle = 0;
            end else if (byte_sync) begin
                if (role == R_INSTR) begin
                    m_addr = data_in[5:0];
                    if (data_in[7]) role = R_DATA;
                    else m_read = 1;
                end else begin
                    if (role == R_DATA) begin m_write = 1; m_dw = data_in; end
                    role = R_INSTR;
                end
                idle = 0;
            end
`ifdef DECODER_TIMEOUT_EN
            else if (role != R_INSTR) begin
                idle++;
                if (idle == TO) begin role = R_INSTR; m_to = 1; idle = 0; end
            end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (en) begin
        chk("read", int'(read), int'(m_read));
        chk("write", int'(write), int'(m_write));
        chk("addr", int'(addr), int'(m_addr));
        chk("data_write", int'(data_write), int'(m_dw));
        chk("data_out", int'(data_out), int'(m_do));
        chk("timeout", int'(timeout), int'(m_to));
        chk("rd_wr_excl", int'(read && write), 0);
        rc += int'(read); wc += int'(write); tc += int'(timeout);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask
    task automatic send(input logic [7:0] b);
        byte_sync = 1'b1; data_in = b;
        @(posedge clk); #1;
        byte_sync = 1'b0; data_in = 8'h00;
    endtask
    task automatic clr;
        rc = 0; wc = 0; tc = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 8'(i * 13 + 1);
        regs[6'h0A] = 8'h55; regs[6'h0C] = 8'h3C; regs[6'h05] = 8'h9A; regs[6'h0B] = 8'hB0;
        #2 rst_n = 1'b0;
        en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_addr", int'(addr), 0);
        chk("rst_data_out", int'(data_out), 0);
        // 1: write 0xAB to 0x00
        clr; send(8'h80); send(8'hAB); tick(2);
        chk("t1_wpulses", wc, 1); chk("t1_rpulses", rc, 0);
        chk("t1_addr", int'(addr), 8'h00); chk("t1_dw", int'(data_write), 8'hAB);
        chk("t1_model_dw", int'(m_dw), 8'hAB);
        // 2: write 0x12 to high byte of index 3
        clr; send(8'hA3); send(8'h12); tick(2);
        chk("t2_wpulses", wc, 1); chk("t2_addr", int'(addr), 8'h23);
        chk("t2_dw", int'(data_write), 8'h12);
        // 3: read 0x0A, strobe next cycle, data two cycles after instruction
        clr; send(8'h0A);
        chk("t3_read_hi", int'(read), 1); chk("t3_addr", int'(addr), 8'h0A);
        tick(1);
        chk("t3_read_lo", int'(read), 0); chk("t3_do", int'(data_out), 8'h55);
        chk("t3_model_do", int'(m_do), 8'h55);
        tick(2); send(8'h00); tick(1);
        chk("t3_rpulses", rc, 1); chk("t3_do_held", int'(data_out), 8'h55);
        // 4: back-to-back write then read
        clr; send(8'h8C); send(8'h01); send(8'h0C); tick(2); send(8'h00); tick(1);
        chk("t4_wpulses", wc, 1); chk("t4_rpulses", rc, 1);
        chk("t4_dw", int'(data_write), 8'h01); chk("t4_do", int'(data_out), 8'h3C);
        // byte arriving during capture is consumed as the response slot
        clr; send(8'h0C); send(8'h8A); send(8'h77); tick(3); send(8'h00); tick(1);
        chk("t4b_wpulses", wc, 0); chk("t4b_rpulses", rc, 2);
        chk("t4b_addr", int'(addr), 8'h37); chk("t4b_do", int'(data_out), int'(regs[6'h37]));
        // write data arriving long after its instruction
        clr; send(8'h91); tick(40); send(8'h6D); tick(1);
`ifdef DECODER_TIMEOUT_EN
        chk("t4c_wpulses", wc, 0); chk("t4c_timeouts", tc, 1);
`else
        chk("t4c_wpulses", wc, 1); chk("t4c_timeouts", tc, 0);
        chk("t4c_dw", int'(data_write), 8'h6D);
`endif
        tick(3);
        // 5: reset in the middle of a write
        clr; send(8'h85); tick(1);
        rst_n = 1'b0; tick(1);
        chk("t5_rst_addr", int'(addr), 0);
        rst_n = 1'b1; tick(1);
        send(8'h05); tick(1); send(8'h00); tick(1);
        chk("t5_wpulses", wc, 0); chk("t5_rpulses", rc, 1);
        chk("t5_addr", int'(addr), 8'h05); chk("t5_do", int'(data_out), 8'h9A);
`ifdef DECODER_TIMEOUT_EN
        // 6: abandoned write times out after TO idle cycles
        clr; send(8'h80); tick(TO - 1);
        chk("t6_no_early", tc, 0);
        tick(1);
        chk("t6_timeout", int'(timeout), 1); chk("t6_model_to", int'(m_to), 1);
        send(8'h0B); tick(1); send(8'h00); tick(1);
        chk("t6_wpulses", wc, 0); chk("t6_rpulses", rc, 1);
        chk("t6_do", int'(data_out), 8'hB0);
        // byte on the expiry cycle wins
        clr; send(8'h80); tick(TO - 1); send(8'hCD); tick(2);
        chk("t6b_timeouts", tc, 0); chk("t6b_wpulses", wc, 1);
        chk("t6b_dw", int'(data_write), 8'hCD);
`endif
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
